// File: rtl/syr2k_operand_streamer.sv
// Operand streamer for the SYR2K core: sweeps (row, col) over the N x N matrices,
// reads A/B/C (row-major and transposed) from 1-cycle RAMs and streams tuples out.
module syr2k_operand_streamer #(
  parameter int N  = 100,
  parameter int DW = 32,
  parameter int AW = 14,
  parameter int IW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          lower,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a_addr0,
  output logic [AW-1:0] a_addr1,
  input  logic [DW-1:0] a_rdata0,
  input  logic [DW-1:0] a_rdata1,
  output logic [AW-1:0] b_addr0,
  output logic [AW-1:0] b_addr1,
  input  logic [DW-1:0] b_rdata0,
  input  logic [DW-1:0] b_rdata1,
  output logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_rdata,
  output logic [DW-1:0] X,
  output logic [DW-1:0] Y,
  output logic [DW-1:0] XT,
  output logic [DW-1:0] YT,
  output logic [DW-1:0] Z,
  output logic [IW-1:0] out_row,
  output logic [IW-1:0] out_col,
  output logic          out_last,
  output logic          out_end,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [AW-1:0] N_A   = AW'(N);
  localparam logic [IW-1:0] NM1_I = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] xt;
    logic [DW-1:0] yt;
    logic [DW-1:0] z;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          last;
    logic          endf;
  } tuple_t;

  state_t        state_q, state_d;
  logic          lower_q, lower_d;
  logic [IW-1:0] row_q, row_d, col_q, col_d;
  logic [AW-1:0] rc_q, rc_d, cr_q, cr_d, base_q, base_d;
  logic          done_q, done_d;

  logic          infl_q;
  logic [IW-1:0] infl_row_q, infl_col_q;
  logic          infl_last_q, infl_end_q;

  tuple_t        fifo_q [2];
  tuple_t        head;
  logic [1:0]    cnt_q;
  logic          wr_q, rd_q;

  logic          pop, issue, last_col, end_tuple;
  logic [2:0]    occ;

  assign head      = fifo_q[rd_q];
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;

  // Occupancy the FIFO will see once everything already issued has landed.
  assign occ       = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
  assign issue     = (state_q == RUN) && (occ < 3'd2);
  assign last_col  = lower_q ? (col_q == row_q) : (col_q == NM1_I);
  assign end_tuple = last_col && (row_q == NM1_I);

  always_comb begin
    state_d = state_q;
    lower_d = lower_q;
    row_d   = row_q;
    col_d   = col_q;
    rc_d    = rc_q;
    cr_d    = cr_q;
    base_d  = base_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          lower_d = lower;
          row_d   = '0;
          col_d   = '0;
          rc_d    = '0;
          cr_d    = '0;
          base_d  = '0;
        end
      end
      RUN: begin
        if (issue) begin
          if (end_tuple) state_d = DRAIN;
          if (last_col) begin
            // base_q tracks row*N so the row step needs only an adder.
            row_d  = row_q + 1'b1;
            col_d  = '0;
            base_d = base_q + N_A;
            rc_d   = base_q + N_A;
            cr_d   = AW'(row_q) + AW'(1);
          end else begin
            col_d  = col_q + 1'b1;
            rc_d   = rc_q + 1'b1;
            cr_d   = cr_q + N_A;
          end
        end
      end
      DRAIN: begin
        if (pop && head.endf) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lower_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      rc_q    <= '0;
      cr_q    <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
      infl_q  <= 1'b0;
      cnt_q   <= 2'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lower_q <= lower_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rc_q    <= rc_d;
      cr_q    <= cr_d;
      base_q  <= base_d;
      done_q  <= done_d;
      infl_q  <= issue;
      cnt_q   <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
      wr_q    <= wr_q ^ infl_q;
      rd_q    <= rd_q ^ pop;
    end
  end

  // Issue stage -> in-flight metadata; RAM return -> FIFO entry.
  always_ff @(posedge clk) begin
    if (issue) begin
      infl_row_q  <= row_q;
      infl_col_q  <= col_q;
      infl_last_q <= last_col;
      infl_end_q  <= end_tuple;
    end
    if (infl_q) begin
      fifo_q[wr_q] <= '{x: a_rdata0, y: b_rdata0, xt: a_rdata1, yt: b_rdata1, z: c_rdata,
                        row: infl_row_q, col: infl_col_q, last: infl_last_q, endf: infl_end_q};
    end
  end

  assign a_addr0  = rc_q;
  assign b_addr0  = rc_q;
  assign c_addr   = rc_q;
  assign a_addr1  = cr_q;
  assign b_addr1  = cr_q;

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign X        = out_valid ? head.x    : '0;
  assign Y        = out_valid ? head.y    : '0;
  assign XT       = out_valid ? head.xt   : '0;
  assign YT       = out_valid ? head.yt   : '0;
  assign Z        = out_valid ? head.z    : '0;
  assign out_row  = out_valid ? head.row  : '0;
  assign out_col  = out_valid ? head.col  : '0;
  assign out_last = out_valid & head.last;
  assign out_end  = out_valid & head.endf;

endmodule

// File: tb/tb_syr2k_operand_streamer.sv
// Bench for syr2k_operand_streamer: N=4 and N=1 instances with RAM models and a
// loop-nest reference model feeding an in-order tuple scoreboard.
module tb_syr2k_operand_streamer;
  localparam int N = 4, DW = 32, AW = 4, IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst, start, lower, out_ready;
  logic busy, done, out_last, out_end, out_valid;
  logic [AW-1:0] a_addr0, a_addr1, b_addr0, b_addr1, c_addr;
  logic [DW-1:0] a_rdata0, a_rdata1, b_rdata0, b_rdata1, c_rdata;
  logic [DW-1:0] X, Y, XT, YT, Z;
  logic [IW-1:0] out_row, out_col;
  logic [DW-1:0] am [16], bm [16], cm [16];

  always @(posedge clk) begin
    a_rdata0 <= am[a_addr0]; a_rdata1 <= am[a_addr1];
    b_rdata0 <= bm[b_addr0]; b_rdata1 <= bm[b_addr1];
    c_rdata  <= cm[c_addr];
  end

  syr2k_operand_streamer #(.N(N), .DW(DW), .AW(AW), .IW(IW)) dut4 (
    .clk(clk), .rst(rst), .start(start), .lower(lower), .busy(busy), .done(done),
    .a_addr0(a_addr0), .a_addr1(a_addr1), .a_rdata0(a_rdata0), .a_rdata1(a_rdata1),
    .b_addr0(b_addr0), .b_addr1(b_addr1), .b_rdata0(b_rdata0), .b_rdata1(b_rdata1),
    .c_addr(c_addr), .c_rdata(c_rdata), .X(X), .Y(Y), .XT(XT), .YT(YT), .Z(Z),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .out_end(out_end),
    .out_valid(out_valid), .out_ready(out_ready));

  logic start1, lower1, ready1, busy1, done1, last1, end1, valid1;
  logic [0:0] aa0, aa1, ba0, ba1, ca1, row1, col1;
  logic [DW-1:0] ar0, ar1, br0, br1, cr1, X1, Y1, XT1, YT1, Z1;
  logic [DW-1:0] a1m [2], b1m [2], c1m [2];

  always @(posedge clk) begin
    ar0 <= a1m[aa0]; ar1 <= a1m[aa1];
    br0 <= b1m[ba0]; br1 <= b1m[ba1];
    cr1 <= c1m[ca1];
  end

  syr2k_operand_streamer #(.N(1), .DW(DW), .AW(1), .IW(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .lower(lower1), .busy(busy1), .done(done1),
    .a_addr0(aa0), .a_addr1(aa1), .a_rdata0(ar0), .a_rdata1(ar1),
    .b_addr0(ba0), .b_addr1(ba1), .b_rdata0(br0), .b_rdata1(br1),
    .c_addr(ca1), .c_rdata(cr1), .X(X1), .Y(Y1), .XT(XT1), .YT(YT1), .Z(Z1),
    .out_row(row1), .out_col(col1), .out_last(last1), .out_end(end1),
    .out_valid(valid1), .out_ready(ready1));

  typedef struct {
    int r; int c; bit last; bit endf;
    logic [DW-1:0] x, y, xt, yt, z;
  } exp_t;
  exp_t exp_q [$];

  int n_vec = 0, n_err = 0;
  int n_xfer, n_done, first_cyc, end_cyc, done_cyc, scen;
  int rmode, stall_left, t0, t0b;
  bit stalled_once, prev_stall;
  logic [191:0] prev_pay;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] pay_obs();
    return {25'd0, out_valid, out_row, out_col, out_last, out_end, X, Y, XT, YT, Z};
  endfunction

  function automatic logic [191:0] pay_exp(input exp_t e);
    return {25'd0, 1'b1, 2'(e.r), 2'(e.c), e.last, e.endf, e.x, e.y, e.xt, e.yt, e.z};
  endfunction

  task automatic build_exp(input bit lw);
    exp_t e;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c <= (lw ? r : N - 1); c++) begin
        e.r = r; e.c = c;
        e.last = (c == (lw ? r : N - 1));
        e.endf = e.last && (r == N - 1);
        e.x = am[r*N + c]; e.y = bm[r*N + c];
        e.xt = am[c*N + r]; e.yt = bm[c*N + r];
        e.z = cm[r*N + c];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic monitor();
    logic [191:0] p;
    exp_t e;
    p = pay_obs();
    if (rst) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) chk("hold_stable", p, prev_pay);
    if (out_valid && out_ready) begin
      if (n_xfer == 0) first_cyc = cyc;
      n_xfer++;
      if (exp_q.size() == 0) chk("extra_xfer", p, 192'd0);
      else begin
        e = exp_q.pop_front();
        chk("tuple", p, pay_exp(e));
      end
      if (out_end) end_cyc = cyc;
      if (scen == 1 && out_row == 2'd1 && out_col == 2'd2)
        chk("t12_X_XT_Y_YT_Z", 192'({X, XT, Y, YT, Z}), 192'({32'd6, 32'd9, 32'd106, 32'd109, 32'd206}));
      if (scen == 2 && out_row == 2'd3 && out_col == 2'd1)
        chk("t31_X_XT", 192'({X, XT}), 192'({32'd13, 32'd7}));
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    prev_stall = out_valid && !out_ready;
    prev_pay = p;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    n_xfer = 0; n_done = 0; first_cyc = -1; end_cyc = -1; done_cyc = -1;
  endtask

  task automatic kick(input bit lw, output int ts);
    start = 1'b1; lower = lw;
    step();
    ts = cyc;
    start = 1'b0; lower = 1'b0;
  endtask

  task automatic set_ready();
    case (rmode)
      0: out_ready = 1'b1;
      1: begin
        if (!stalled_once && n_xfer == 3) begin stalled_once = 1'b1; stall_left = 5; end
        if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
        else out_ready = stalled_once ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run(input int max, input int stop_xfer, input bit stop_end);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0 && n_done > 0) break;
      if (stop_xfer >= 0 && n_xfer >= stop_xfer) break;
      if (stop_end && end_cyc >= 0) break;
      set_ready();
      step();
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 16; i++) begin
      am[i] = DW'(i); bm[i] = DW'(100 + i); cm[i] = DW'(200 + i);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit lw;
    rst = 1'b1; start = 1'b0; lower = 1'b0; out_ready = 1'b1;
    start1 = 1'b0; lower1 = 1'b0; ready1 = 1'b1;
    scen = 0; rmode = 0; stall_left = 0; stalled_once = 1'b0; prev_stall = 1'b0; prev_pay = '0;
    fill_pattern();
    for (int i = 0; i < 2; i++) begin
      a1m[i] = $urandom; b1m[i] = $urandom; c1m[i] = $urandom;
    end
    clr_stats();
    @(posedge clk); #1;
    step(); step(); step();
    chk("rst_outs_n4", 192'({busy, done, out_valid, out_last, out_end, out_row, out_col, a_addr0, a_addr1,
        b_addr0, b_addr1, c_addr, X, Y, XT, YT, Z}), 192'd0);
    chk("rst_outs_n1", 192'({busy1, done1, valid1, last1, end1, row1, col1, aa0, aa1, ba0, ba1, ca1,
        X1, Y1, XT1, YT1, Z1}), 192'd0);
    rst = 1'b0;
    step();

    // Full sweep, no backpressure.
    scen = 1; clr_stats(); build_exp(1'b0); rmode = 0; out_ready = 1'b1;
    kick(1'b0, t0);
    run(60, -1, 1'b0); step(); step();
    chk("s1_count", n_xfer, 16);
    chk("s1_first_latency", first_cyc, t0 + 2);
    chk("s1_end_cycle", end_cyc, t0 + 17);
    chk("s1_done_cycle", done_cyc, end_cyc + 1);
    chk("s1_ndone", n_done, 1);
    chk("s1_left", exp_q.size(), 0);
    chk("s1_idle", 192'({busy, out_valid}), 192'd0);

    // Lower-triangle sweep.
    scen = 2; clr_stats(); build_exp(1'b1);
    kick(1'b1, t0);
    run(60, -1, 1'b0); step(); step();
    chk("s2_count", n_xfer, 10);
    chk("s2_first_latency", first_cyc, t0 + 2);
    chk("s2_done_cycle", done_cyc, end_cyc + 1);
    chk("s2_ndone", n_done, 1);

    // Backpressure: 5-cycle stall at tuple 3, then random ready.
    scen = 3; clr_stats(); build_exp(1'b0); rmode = 1; stalled_once = 1'b0; stall_left = 0;
    kick(1'b0, t0);
    run(400, -1, 1'b0);
    rmode = 0; out_ready = 1'b1; step(); step();
    chk("s3_count", n_xfer, 16);
    chk("s3_ndone", n_done, 1);
    chk("s3_left", exp_q.size(), 0);

    // start while busy is ignored; start in the done cycle chains a new sweep.
    scen = 4; clr_stats(); build_exp(1'b0); rmode = 0;
    kick(1'b0, t0);
    run(60, 5, 1'b0);
    start = 1'b1; lower = 1'b1; step(); start = 1'b0; lower = 1'b0;
    run(60, -1, 1'b1);
    chk("s4_first_count", n_xfer, 16);
    build_exp(1'b1);
    start = 1'b1; lower = 1'b1;
    step();
    t0b = cyc; start = 1'b0; lower = 1'b0;
    chk("s4_single_done", n_done, 1);
    chk("s4_done_cycle", done_cyc, end_cyc + 1);
    clr_stats();
    run(60, -1, 1'b0); step(); step();
    chk("s4_chain_latency", first_cyc, t0b + 2);
    chk("s4_chain_count", n_xfer, 10);
    chk("s4_chain_ndone", n_done, 1);

    // Reset after tuple 7, then a clean restart.
    scen = 5; clr_stats(); build_exp(1'b0);
    kick(1'b0, t0);
    run(60, 7, 1'b0);
    rst = 1'b1; out_ready = 1'b0;
    step();
    chk("s5_after_rst", 192'({busy, done, out_valid}), 192'd0);
    rst = 1'b0; out_ready = 1'b1; exp_q.delete(); clr_stats();
    for (int i = 0; i < 6; i++) step();
    chk("s5_no_done", n_done, 0);
    chk("s5_no_valid", n_xfer, 0);
    clr_stats(); build_exp(1'b0);
    kick(1'b0, t0);
    run(60, -1, 1'b0); step(); step();
    chk("s5_restart_latency", first_cyc, t0 + 2);
    chk("s5_restart_count", n_xfer, 16);
    chk("s5_restart_ndone", n_done, 1);

    // N=1 build.
    start1 = 1'b1; ready1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("n1_e0", 192'({busy1, valid1}), 192'(2'b10));
    step();
    chk("n1_e1", 192'({busy1, valid1}), 192'(2'b10));
    step();
    chk("n1_tuple", 192'({valid1, row1, col1, last1, end1, X1, Y1, XT1, YT1, Z1}),
        192'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, a1m[0], b1m[0], a1m[0], b1m[0], c1m[0]}));
    step();
    chk("n1_done", 192'({done1, busy1, valid1}), 192'(3'b100));
    step();
    chk("n1_done_off", 192'(done1), 192'd0);

    // Randomised contents, mode and ready.
    scen = 7;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        am[i] = $urandom; bm[i] = $urandom; cm[i] = $urandom;
      end
      lw = 1'($urandom_range(0, 1));
      clr_stats(); build_exp(lw); out_ready = 1'b1; rmode = 2;
      kick(lw, t0);
      run(600, -1, 1'b0);
      rmode = 0; out_ready = 1'b1; step(); step(); step();
      chk("rnd_count", n_xfer, lw ? 10 : 16);
      chk("rnd_ndone", n_done, 1);
      chk("rnd_left", exp_q.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/syr2k_operand_streamer.md
# syr2k_operand_streamer

Hardware operand source for the SYR2K compute core. It walks the (row, col) index space of the N×N operand matrices and reads A, B and C from on-chip synchronous RAMs. It presents each operand tuple X=A[r][c], Y=B[r][c], XT=A[c][r], YT=B[c][r], Z=C[r][c] to the core over a valid/ready stream. It sits between the matrix RAMs and the core's X/Y/Z/XT/YT inputs, and replaces the simulation-only driver loop.

## Interface
- N, 100: matrix dimension; 1 ≤ N, N*N ≤ 2^AW
- DW, 32: element width
- AW, 14: RAM address width; address = row*N + col
- IW, 7: index width for out_row/out_col; N−1 < 2^IW

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a sweep; ignored while busy
- lower  in  1  sampled with start; 1 = lower triangle only (col ≤ row)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion
- a_addr0, a_addr1  out  AW  A RAM read ports (row-major, transposed)
- a_rdata0, a_rdata1  in  DW  A RAM read data, 1-cycle latency
- b_addr0, b_addr1  out  AW  B RAM read ports (row-major, transposed)
- b_rdata0, b_rdata1  in  DW  B RAM read data, 1-cycle latency
- c_addr  out  AW  C RAM read port
- c_rdata  in  DW  C RAM read data, 1-cycle latency
- X, Y, XT, YT, Z  out  DW  operand tuple
- out_row, out_col  out  IW  indices of current tuple
- out_last  out  1  last tuple of a row
- out_end  out  1  last tuple of the sweep
- out_valid  out  1  tuple valid
- out_ready  in  1  core accepts tuple; transfer = out_valid & out_ready

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN on start. The transition clears the counters and latches lower. busy = 1 in RUN and DRAIN.
- Iteration order: row r = 0..N−1 outer, col c inner. c runs 0..N−1 when lower = 0, and 0..r when lower = 1. Tuple count is N² or N(N+1)/2.
- Addresses come from incremental counters, with no multiplier:
  - addr_rc += 1 per column. With lower = 1, the row-advance step instead sets it to (r+1)*N.
  - addr_cr += N per column. On row advance it resets to r+1.
- Every read port is driven each cycle:
  - a_addr0 = b_addr0 = c_addr = addr_rc
  - a_addr1 = b_addr1 = addr_cr
- Read-issue rule: an issue happens in a cycle where issue-enable is high. One tuple read is issued, its metadata (row, col, last, end) enters a 1-deep in-flight register, and the counters advance.
- Issue-enable is high when state = RUN and (fifo_count + inflight − pop) < 2.
- Returned data plus metadata are written into a 2-entry output FIFO one cycle after issue. The FIFO head drives the outputs.
- RUN → DRAIN after issuing the out_end tuple.
- DRAIN → IDLE on the transfer of the out_end tuple. done = 1 for exactly the next cycle, and busy falls at the same edge.
- A start in the done cycle is accepted (the state is already IDLE).
- Outputs are stable while out_valid & !out_ready. No tuple is dropped, duplicated or reordered.
- Reset value of every output is 0.
- rst mid-sweep:
  - the next cycle has state IDLE, FIFO empty and in-flight cleared
  - out_valid = 0, busy = 0, done = 0
  - RAM data returning afterward is discarded

## Timing
- Start sampled at edge E0. The first address is driven after E0, RAM captures it at E1, and data lands in the FIFO at E2. out_valid is high after E2, a 2-cycle latency.
- With out_ready held high, one tuple transfers per cycle with no bubbles. The sweep occupies tuple_count + 2 cycles from start to the last transfer.
- Outstanding reads never exceed 2 − fifo_count. There is no overflow under arbitrary out_ready patterns.
- out_ready going high after a stall resumes 1/cycle throughput within 1 cycle.
- N = 1: a single tuple (0,0) with out_last = out_end = 1. The sweep goes RUN → DRAIN in one cycle.

## Test plan
- N=4, lower=0, out_ready=1, RAMs loaded A[i][j]=i*4+j, B[i][j]=100+i*4+j, C[i][j]=200+i*4+j. Required response:
  - 16 consecutive transfers starting 2 cycles after start
  - tuple (1,2): X=6, XT=9, Y=106, YT=109, Z=206
  - out_last on col 3; out_end on (3,3)
  - done one cycle after that transfer
- N=4, lower=1: 10 tuples in order (0,0),(1,0),(1,1),(2,0)…(3,3). out_last on each diagonal element; tuple (3,1): X=13, XT=7.
- Backpressure: out_ready low for 5 cycles at tuple 3, then random 50% toggling. Outputs must be held stable during stalls, the sequence must match scenario 1 exactly, and the read-address count must never exceed transfers + 2.
- start pulsed while busy (mid-sweep): ignored, with a single done. start in the done cycle: a second sweep begins with 2-cycle latency.
- rst asserted after tuple 7 transfers: the next cycle has out_valid=0, busy=0, no done ever. A fresh start restarts at (0,0) with correct data.
- N=1 build: one tuple (0,0) with out_last=out_end=1, and done the cycle after its transfer.
